// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and default sizes for the data-memory arbiter
//
// Purpose : requester identifiers, the read-response tag carried down the
//           response pipe, and the default parameter values of dmem_arbiter.
// Ports   : none (package).

package dmem_arb_pkg;

   typedef enum logic {
      PORT_CORE = 1'b0,
      PORT_LDR  = 1'b1
   } port_id_e;

   // One entry of the read-response pipe: which port gets the data, if any.
   typedef struct packed {
      logic     valid;
      port_id_e port;
   } rsp_tag_t;

   localparam int DMEM_DATA_W   = 32;
   localparam int DMEM_ADDR_W   = 9;
   localparam int DMEM_MAX_WAIT = 8;

   function automatic rsp_tag_t make_tag(input logic valid, input port_id_e port);
      rsp_tag_t t;
      t.valid = valid;
      t.port  = port;
      return t;
   endfunction

endpackage

// File: rtl/dmem_arb_rsp_pipe.sv
// rtl/dmem_arb_rsp_pipe.sv - read-response tag pipe and rdata/rvalid demux
//
// Purpose : follows every read issued to the memory with a {valid, port} tag
//           and steers the returning memory data to the port that issued it.
// Ports   :
//   clk, reset          clock, asynchronous active-low reset
//   issue_valid         a read handshake happened this cycle
//   issue_port          port that owns that read
//   rd_data             memory read data (valid 1 cycle after rd)
//   core_rvalid/rdata   core read response
//   ldr_rvalid/rdata    loader read response

module dmem_arb_rsp_pipe
   import dmem_arb_pkg::*;
#(
   parameter int DATA_W = DMEM_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issue_valid,
   input  port_id_e          issue_port,
   input  logic [DATA_W-1:0] rd_data,
   output logic              core_rvalid,
   output logic [DATA_W-1:0] core_rdata,
   output logic              ldr_rvalid,
   output logic [DATA_W-1:0] ldr_rdata
);

   // tag_cmd lines up with rd on the memory port, tag_rsp with rd_data.
   rsp_tag_t          tag_cmd;
   rsp_tag_t          tag_rsp;
   logic [DATA_W-1:0] core_hold;
   logic [DATA_W-1:0] ldr_hold;
   logic              core_hit;
   logic              ldr_hit;

   assign core_hit = tag_rsp.valid && (tag_rsp.port == PORT_CORE);
   assign ldr_hit  = tag_rsp.valid && (tag_rsp.port == PORT_LDR);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_cmd   <= '0;
         tag_rsp   <= '0;
         core_hold <= '0;
         ldr_hold  <= '0;
      end else begin
         tag_cmd <= make_tag(issue_valid, issue_port);
         tag_rsp <= tag_cmd;
         // rd_data is only looked at while a response tag is live.
         if (core_hit) core_hold <= rd_data;
         if (ldr_hit)  ldr_hold  <= rd_data;
      end
   end

   // The owning port sees the memory word in the response cycle itself; the
   // hold register keeps it afterwards so the other port's rdata never moves.
   assign core_rvalid = core_hit;
   assign ldr_rvalid  = ldr_hit;
   assign core_rdata  = core_hit ? rd_data : core_hold;
   assign ldr_rdata   = ldr_hit  ? rd_data : ldr_hold;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/loader arbiter in front of the single data-memory port
//
// Purpose : grants one of two requesters per cycle (core first), registers the
//           granted access onto the memory port and returns read data to the
//           issuing port two cycles after the handshake.
// Build   : define DMEM_ARB_STARVE_GUARD_EN to enable the loader starvation
//           guard (forced loader grant after MAX_WAIT waiting cycles).
// Ports   :
//   clk, reset                    clock, asynchronous active-low reset
//   core_req/we/addr/wdata        core request
//   core_gnt, core_stall          core handshake / stall
//   core_rvalid, core_rdata       core read response
//   ldr_req/we/addr/wdata         loader request
//   ldr_gnt                       loader handshake
//   ldr_rvalid, ldr_rdata         loader read response
//   wr, rd, addr, wr_data         registered memory command
//   rd_data                       memory read data, valid 1 cycle after rd

module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DATA_W   = DMEM_DATA_W,
   parameter int ADDR_W   = DMEM_ADDR_W,
   parameter int MAX_WAIT = DMEM_MAX_WAIT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_gnt,
   output logic              core_stall,
   output logic              core_rvalid,
   output logic [DATA_W-1:0] core_rdata,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_gnt,
   output logic              ldr_rvalid,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              wr,
   output logic              rd,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wr_data,
   input  logic [DATA_W-1:0] rd_data
);

   logic              force_ldr;
   logic              hs;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   port_id_e          sel_port;

`ifdef DMEM_ARB_STARVE_GUARD_EN
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   logic [WAIT_W-1:0] wait_cnt;

   // Counts cycles the loader has been asking without being served.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt <= '0;
      end else if (ldr_req && !ldr_gnt) begin
         if (wait_cnt != WAIT_W'(MAX_WAIT))
            wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
         wait_cnt <= '0;
      end
   end

   // Only overrides the core when both are asking; a lone requester is
   // always granted anyway.
   assign force_ldr = core_req && ldr_req && (wait_cnt == WAIT_W'(MAX_WAIT));
`else
   assign force_ldr = 1'b0;
`endif

   // Grants are held off entirely while reset is asserted.
   assign core_gnt   = reset && core_req && !force_ldr;
   assign ldr_gnt    = reset && ldr_req && (!core_req || force_ldr);
   assign core_stall = core_req && !core_gnt;

   assign hs        = core_gnt || ldr_gnt;
   assign sel_we    = ldr_gnt ? ldr_we    : core_we;
   assign sel_addr  = ldr_gnt ? ldr_addr  : core_addr;
   assign sel_wdata = ldr_gnt ? ldr_wdata : core_wdata;
   assign sel_port  = ldr_gnt ? PORT_LDR  : PORT_CORE;

   // Memory command: strobes last one cycle, addr/wr_data keep their value
   // between accesses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr      <= 1'b0;
         rd      <= 1'b0;
         addr    <= '0;
         wr_data <= '0;
      end else begin
         wr <= hs && sel_we;
         rd <= hs && !sel_we;
         if (hs) begin
            addr    <= sel_addr;
            wr_data <= sel_wdata;
         end
      end
   end

   dmem_arb_rsp_pipe #(
      .DATA_W (DATA_W)
   ) u_rsp_pipe (
      .clk         (clk),
      .reset       (reset),
      .issue_valid (hs && !sel_we),
      .issue_port  (sel_port),
      .rd_data     (rd_data),
      .core_rvalid (core_rvalid),
      .core_rdata  (core_rdata),
      .ldr_rvalid  (ldr_rvalid),
      .ldr_rdata   (ldr_rdata)
   );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter

module tb_dmem_arbiter;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 9;
   localparam int MAX_WAIT = 8;
`ifdef DMEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              core_req = 1'b0, core_we = 1'b0;
   logic [ADDR_W-1:0] core_addr = '0;
   logic [DATA_W-1:0] core_wdata = '0;
   logic              core_gnt, core_stall, core_rvalid;
   logic [DATA_W-1:0] core_rdata;
   logic              ldr_req = 1'b0, ldr_we = 1'b0;
   logic [ADDR_W-1:0] ldr_addr = '0;
   logic [DATA_W-1:0] ldr_wdata = '0;
   logic              ldr_gnt, ldr_rvalid;
   logic [DATA_W-1:0] ldr_rdata;
   logic              wr, rd;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] rd_data;

   dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
      .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] init_word(input int a);
      if (a == 16) return 32'hDEAD_BEEF;
      return 32'hA500_0000 ^ (32'(a) * 32'h0101_0101);
   endfunction

   // Synchronous memory environment: data appears the cycle after rd.
   logic              mem_init = 1'b1;
   logic [DATA_W-1:0] mem [512];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
      end else begin
         if (wr) mem[addr] <= wr_data;
         if (rd) rd_data <= mem[addr];
      end
   end

   // Reference model: memory contents in grant order and expected responses.
   typedef struct {
      int                due;
      bit                port;
      logic [DATA_W-1:0] data;
   } exp_rsp_t;

   logic [DATA_W-1:0] ref_mem [512];
   exp_rsp_t          rq[$];
   int                k = 0;
   int                wcnt = 0;
   logic              exp_wr = 0, exp_rd = 0;
   logic [ADDR_W-1:0] exp_addr = '0;
   logic [DATA_W-1:0] exp_wdata = '0;
   logic [DATA_W-1:0] core_hold = '0, ldr_hold = '0;
   int                n_checks = 0;
   int                n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, k, obs, exp);
      end
   endtask

   task automatic model_reset();
      rq.delete();
      wcnt = 0;
      exp_wr = 0; exp_rd = 0; exp_addr = '0; exp_wdata = '0;
      core_hold = '0; ldr_hold = '0;
   endtask

   // Compare registered outputs for the current cycle.
   task automatic check_outputs();
      logic exp_cv, exp_lv;
      exp_rsp_t r;
      k++;
      exp_cv = 0; exp_lv = 0;
      check_eq("wr", wr, exp_wr);
      check_eq("rd", rd, exp_rd);
      check_eq("addr", addr, exp_addr);
      check_eq("wr_data", wr_data, exp_wdata);
      if (rq.size() > 0 && rq[0].due == k) begin
         r = rq.pop_front();
         if (r.port) begin exp_lv = 1; ldr_hold = r.data; end
         else        begin exp_cv = 1; core_hold = r.data; end
      end
      check_eq("core_rvalid", core_rvalid, exp_cv);
      check_eq("core_rdata", core_rdata, core_hold);
      check_eq("ldr_rvalid", ldr_rvalid, exp_lv);
      check_eq("ldr_rdata", ldr_rdata, ldr_hold);
   endtask

   // Drive one cycle of requests, check grants, advance the model.
   task automatic drive(input logic cr, input logic cw, input logic [ADDR_W-1:0] ca,
                        input logic [DATA_W-1:0] cd, input logic lr, input logic lw,
                        input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld,
                        output logic cg, output logic lg);
      logic we;
      logic [ADDR_W-1:0] a;
      core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
      ldr_req = lr; ldr_we = lw; ldr_addr = la; ldr_wdata = ld;
      #1;
      cg = cr && !(GUARD && lr && wcnt == MAX_WAIT);
      lg = lr && !cg;
      check_eq("core_gnt", core_gnt, cg);
      check_eq("ldr_gnt", ldr_gnt, lg);
      check_eq("core_stall", core_stall, cr && !cg);
      if (lr && !lg) wcnt = (wcnt < MAX_WAIT) ? wcnt + 1 : MAX_WAIT;
      else           wcnt = 0;
      exp_wr = 0; exp_rd = 0;
      if (cg || lg) begin
         we = cg ? cw : lw;
         a  = cg ? ca : la;
         exp_addr  = a;
         exp_wdata = cg ? cd : ld;
         if (we) begin
            exp_wr = 1;
            ref_mem[a] = exp_wdata;
         end else begin
            exp_rd = 1;
            rq.push_back('{due: k + 2, port: lg, data: ref_mem[a]});
         end
      end
   endtask

   task automatic step(input logic cr, input logic cw, input logic [ADDR_W-1:0] ca,
                       input logic [DATA_W-1:0] cd, input logic lr, input logic lw,
                       input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld,
                       output logic cg, output logic lg);
      @(negedge clk);
      check_outputs();
      drive(cr, cw, ca, cd, lr, lw, la, ld, cg, lg);
   endtask

   task automatic idle(input int n);
      logic g0, g1;
      for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0, g0, g1);
   endtask

   logic              cg, lg;
   logic              c_pend, c_we, l_pend, l_we;
   logic [ADDR_W-1:0] c_a, l_a;
   logic [DATA_W-1:0] c_d, l_d;
   int                first_ldr;

   initial begin
      for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);

      // Reset state, with both requests up to show grants are blocked.
      core_req = 1; ldr_req = 1;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      mem_init = 0;
      check_eq("rst_wr", wr, 0);
      check_eq("rst_rd", rd, 0);
      check_eq("rst_addr", addr, 0);
      check_eq("rst_core_gnt", core_gnt, 0);
      check_eq("rst_ldr_gnt", ldr_gnt, 0);
      check_eq("rst_core_rvalid", core_rvalid, 0);
      check_eq("rst_ldr_rdata", ldr_rdata, 0);
      core_req = 0; ldr_req = 0;
      reset = 1;

      // Core-only read of 0x010.
      step(1, 0, 9'h010, '0, 0, 0, '0, '0, cg, lg);
      idle(3);

      // Core write and loader read to 0x005 in the same cycle.
      step(1, 1, 9'h005, 32'h1234, 1, 0, 9'h005, '0, cg, lg);
      step(0, 0, '0, '0, 1, 0, 9'h005, '0, cg, lg);
      idle(3);

      // Back-to-back alternating reads.
      step(1, 0, 9'h001, '0, 0, 0, '0, '0, cg, lg);
      step(0, 0, '0, '0, 1, 0, 9'h002, '0, cg, lg);
      step(1, 0, 9'h003, '0, 0, 0, '0, '0, cg, lg);
      idle(3);

      // Both held high: forced loader grant in cycle MAX_WAIT+1 only with guard.
      first_ldr = -1;
      for (int i = 1; i <= 20; i++) begin
         step(1, 0, 9'h007, '0, 1, 0, 9'h008, '0, cg, lg);
         if (ldr_gnt && first_ldr < 0) first_ldr = i;
      end
      check_eq("first_forced_ldr_gnt", 64'(first_ldr), GUARD ? 64'(MAX_WAIT + 1) : 64'(-1));
      idle(3);

      // Reset one cycle after a read handshake.
      step(1, 0, 9'h020, '0, 0, 0, '0, '0, cg, lg);
      @(negedge clk);
      check_outputs();
      reset = 0;
      #1;
      model_reset();
      check_eq("arst_rd", rd, 0);
      check_eq("arst_addr", addr, 0);
      check_eq("arst_core_gnt", core_gnt, 0);
      check_eq("arst_core_rvalid", core_rvalid, 0);
      core_req = 0;
      @(posedge clk);
      @(negedge clk);
      reset = 1;
      idle(3);
      step(0, 0, '0, '0, 1, 0, 9'h010, '0, cg, lg);
      idle(3);

      // Randomized traffic with requesters holding until granted.
      c_pend = 0; l_pend = 0;
      c_we = 0; l_we = 0; c_a = '0; l_a = '0; c_d = '0; l_d = '0;
      for (int i = 0; i < 600; i++) begin
         if (!c_pend && $urandom_range(0, 9) < 6) begin
            c_pend = 1; c_we = ($urandom_range(0, 2) == 0);
            c_a = 9'($urandom_range(0, 15)); c_d = $urandom;
         end
         if (!l_pend && $urandom_range(0, 9) < 5) begin
            l_pend = 1; l_we = ($urandom_range(0, 2) == 0);
            l_a = 9'($urandom_range(0, 15)); l_d = $urandom;
         end
         step(c_pend, c_we, c_a, c_d, l_pend, l_we, l_a, l_d, cg, lg);
         if (cg) c_pend = 0;
         if (lg) l_pend = 0;
      end
      idle(4);
      check_eq("rsp_queue_drained", 64'(rq.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data-memory port between the pipeline MEM stage (core) and an external loader/debug requester. It sits between the Datapath MEM stage and the data memory. It issues at most one registered memory command per cycle and routes synchronous read data back to the requester that issued the read. The core has priority; a wait counter bounds loader starvation.

## Interface

Parameters:
- DATA_W, 32, data width
- ADDR_W, 9, word address width
- MAX_WAIT, 8, loader wait cycles before forced grant (≥1)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- core_req  in  1  core access request
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core write data
- core_gnt  out  1  core handshake accepted this cycle
- core_stall  out  1  core_req & ~core_gnt
- core_rvalid  out  1  core read data valid
- core_rdata  out  DATA_W  core read data
- ldr_req  in  1  loader request
- ldr_we  in  1  loader write enable
- ldr_addr  in  ADDR_W  loader address
- ldr_wdata  in  DATA_W  loader write data
- ldr_gnt  out  1  loader handshake accepted
- ldr_rvalid  out  1  loader read data valid
- ldr_rdata  out  DATA_W  loader read data
- wr  out  1  memory write strobe (registered)
- rd  out  1  memory read strobe (registered)
- addr  out  ADDR_W  memory address (registered)
- wr_data  out  DATA_W  memory write data (registered)
- rd_data  in  DATA_W  memory read data, valid 1 cycle after rd

## Operation

- Handshake: a transfer occurs in a cycle where req & gnt is 1. Grants are combinational from current requests and state. A requester holds req/we/addr/wdata stable until granted. At most one grant per cycle.
- Arbitration:
  - Only one requester asserts req: it is granted.
  - Both assert req: the core wins, unless the starvation guard fires (see Configuration).
- Command stage: on a handshake, the granted request is registered into wr/rd/addr/wr_data for exactly one cycle.
  - No handshake: wr = rd = 0. addr and wr_data hold their last value.
- Response pipe: a 2-entry tag shift register {valid, port} follows each read. The tag is captured at the handshake and advanced with the command.
  - When the tag reaches the response stage, rd_data is registered into that port's rdata and that port's rvalid pulses for 1 cycle.
  - The other port's rdata holds its value.
- Writes produce no response.
- Ordering: commands reach memory in grant order. A write followed by a read to the same address returns the new data.
- Wait counter (width $clog2(MAX_WAIT+1)):
  - Increments each cycle ldr_req & ~ldr_gnt.
  - Saturates at MAX_WAIT.
  - Clears on ldr_gnt or when ldr_req = 0.
- Reset: asynchronous, takes effect immediately. In-flight reads are dropped and no rvalid is produced for them.
  - Reset values: wr, rd, addr, wr_data, core_rvalid, core_rdata, ldr_rvalid, ldr_rdata = 0. Wait counter = 0. Tags invalid.
  - core_gnt = ldr_gnt = 0 while reset = 0.

## Timing

- Cycle T: handshake.
- T+1: wr or rd high on the memory port.
- T+2: read data registered; rvalid = 1 in cycle T+2.
- Read latency is 2 cycles from handshake. Throughput is 1 access/cycle, and back-to-back handshakes are fully pipelined.
- core_stall is combinational in the same cycle as core_req.
- Forced loader grant occurs in the cycle after the counter reaches MAX_WAIT while both requests stay high. The core stalls exactly that one cycle.
- Simultaneous ldr_gnt and counter saturation: the counter clears in the next cycle.
- rd_data is sampled only in cycles where the response-stage tag is valid.

## Configuration

- DMEM_ARB_STARVE_GUARD_EN defined:
  - When the wait counter equals MAX_WAIT and both requests are high, ldr_gnt = 1 and core_gnt = 0.
  - Afterwards the core regains priority.
- Not defined:
  - Strict fixed core priority; the loader can starve indefinitely.
  - The wait counter is not instantiated. Port list is unchanged.

## Structure

- dmem_arb_pkg:
  - port_id_e {PORT_CORE = 1'b0, PORT_LDR = 1'b1}
  - rsp_tag_t struct {valid, port_id_e port}
  - Default width constants
- Sub-module dmem_arb_rsp_pipe: 2-stage tag shift register plus rdata/rvalid demux.
- Grant logic, command register and wait counter stay in the top module.

## Test plan

- Core-only read, addr 0x010, memory word 0xDEADBEEF → wr = 0, rd = 1, addr = 0x010 at T+1; core_rvalid = 1 and core_rdata = 0xDEADBEEF at T+2; ldr_rvalid = 0.
- Both requesting, core write 0x005 = 0x1234 and loader read 0x005, loader waits → core granted first; loader's later read returns 0x1234.
- Guard enabled, MAX_WAIT = 8, core_req held high, ldr_req held high → ldr_gnt in cycle 9 only, core_stall = 1 in that cycle; without the macro, ldr_gnt never asserts.
- Alternating back-to-back reads core/loader/core to 0x001/0x002/0x003 → one rd pulse per cycle; rvalids return on the correct ports in order with matching data.
- reset driven low one cycle after a read handshake → all outputs 0 immediately; no rvalid after release; a first access after release behaves normally.
